// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Purpose  : MEM stage of the 5-stage MIPS pipeline. Performs word loads and
//            stores to an internal data memory with MEM_LATENCY-edge latency,
//            stalls upstream while an access is in flight, and drives the
//            MEM/WB pipeline register plus the registered branch decision.
// Ports    : clk, reset (sync, active-high)
//            *_ex_mem inputs  : EX/MEM slot (valid, address/result, store
//                               data, dest reg, zero, branch target, ctrl)
//            stall            : upstream must hold all *_ex_mem inputs
//            *_mem_wb outputs : MEM/WB slot (valid, load data, ALU result,
//                               dest reg, regWrite, memToReg)
//            pc_src, branch_target : registered taken-branch pulse/target
//            mem_align_err    : sticky misaligned-access flag (ALIGN_CHECK_EN)
// Options  : `define ALIGN_CHECK_EN enables misaligned mem-op detection.
// Revision : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_ex_mem,
    input  logic [31:0] alu_result_ex_mem,
    input  logic [31:0] write_data_ex_mem,
    input  logic [4:0]  write_register_ex_mem,
    input  logic        zero_ex_mem,
    input  logic [31:0] branch_address_ex_mem,
    input  logic        ctrl_memRead_ex_mem,
    input  logic        ctrl_memWrite_ex_mem,
    input  logic        ctrl_branch_ex_mem,
    input  logic        ctrl_regWrite_ex_mem,
    input  logic        ctrl_memToReg_ex_mem,
    output logic        stall,
    output logic        valid_mem_wb,
    output logic [31:0] read_data_mem_wb,
    output logic [31:0] alu_result_mem_wb,
    output logic [4:0]  write_register_mem_wb,
    output logic        ctrl_regWrite_mem_wb,
    output logic        ctrl_memToReg_mem_wb,
    output logic        pc_src,
`ifdef ALIGN_CHECK_EN
    output logic        mem_align_err,
`endif
    output logic [31:0] branch_target
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);
    // Counter only needs to hold MEM_LATENCY-2 (the WAIT cycles before completion)
    localparam int c_CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'((MEM_LATENCY > 2) ? (MEM_LATENCY - 2) : 0);
    localparam logic c_MULTI = (MEM_LATENCY > 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;

    // Hold registers: snapshot of the op accepted into WAIT
    logic [31:0] r_h_alu, r_h_wdata, r_h_baddr;
    logic [4:0]  r_h_wreg;
    logic        r_h_rd, r_h_wr, r_h_br, r_h_zero, r_h_regw, r_h_m2r;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic               w_in_wait;
    logic               w_mem_op_live;
    logic               w_valid, w_rd, w_wr, w_br, w_zero, w_regw, w_m2r;
    logic [31:0]        w_alu, w_wdata, w_baddr;
    logic [4:0]         w_wreg;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_start, w_complete, w_misalign, w_store, w_load;

    assign w_in_wait     = (r_state == c_ST_WAIT);
    assign w_mem_op_live = valid_ex_mem & (ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem);

    // In WAIT the live inputs are ignored; the held op is always a valid mem op
    assign w_valid = w_in_wait ? 1'b1      : valid_ex_mem;
    assign w_rd    = w_in_wait ? r_h_rd    : ctrl_memRead_ex_mem;
    assign w_wr    = w_in_wait ? r_h_wr    : ctrl_memWrite_ex_mem;
    assign w_br    = w_in_wait ? r_h_br    : ctrl_branch_ex_mem;
    assign w_zero  = w_in_wait ? r_h_zero  : zero_ex_mem;
    assign w_regw  = w_in_wait ? r_h_regw  : ctrl_regWrite_ex_mem;
    assign w_m2r   = w_in_wait ? r_h_m2r   : ctrl_memToReg_ex_mem;
    assign w_alu   = w_in_wait ? r_h_alu   : alu_result_ex_mem;
    assign w_wdata = w_in_wait ? r_h_wdata : write_data_ex_mem;
    assign w_baddr = w_in_wait ? r_h_baddr : branch_address_ex_mem;
    assign w_wreg  = w_in_wait ? r_h_wreg  : write_register_ex_mem;

    // Upper address bits are dropped, so addresses wrap modulo the memory size
    assign w_idx = w_alu[c_IDX_W+1:2];

`ifdef ALIGN_CHECK_EN
    assign w_misalign = w_valid & (w_rd | w_wr) & (w_alu[1:0] != 2'b00);
    logic w_unused;
    assign w_unused = ^w_alu[31:c_IDX_W+2];
`else
    assign w_misalign = 1'b0;
    logic w_unused;
    assign w_unused = ^{w_alu[31:c_IDX_W+2], w_alu[1:0]};
`endif

    assign w_start    = !w_in_wait && w_mem_op_live && c_MULTI;
    assign w_complete = w_in_wait ? (r_cnt == '0) : !(w_mem_op_live && c_MULTI);
    // Reset on the completing edge aborts the store
    assign w_store    = !reset && w_complete && w_valid && w_wr && !w_misalign;
    assign w_load     = w_valid && w_rd && !w_misalign;

    assign stall = !reset && (w_in_wait ? (r_cnt != '0) : (w_mem_op_live && c_MULTI));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state               <= c_ST_IDLE;
            r_cnt                 <= '0;
            valid_mem_wb          <= 1'b0;
            read_data_mem_wb      <= '0;
            alu_result_mem_wb     <= '0;
            write_register_mem_wb <= '0;
            ctrl_regWrite_mem_wb  <= 1'b0;
            ctrl_memToReg_mem_wb  <= 1'b0;
            pc_src                <= 1'b0;
            branch_target         <= '0;
`ifdef ALIGN_CHECK_EN
            mem_align_err         <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_state <= c_ST_WAIT;
                        r_cnt   <= c_CNT_INIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_W'(1);
                    else             r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase

            if (w_complete && w_valid) begin
                valid_mem_wb          <= 1'b1;
                // Nonblocking write in parallel means read+write returns pre-write data
                read_data_mem_wb      <= w_load ? r_mem[w_idx] : 32'h0;
                alu_result_mem_wb     <= w_alu;
                write_register_mem_wb <= w_wreg;
                ctrl_regWrite_mem_wb  <= w_regw & !w_misalign;
                ctrl_memToReg_mem_wb  <= w_m2r;
                pc_src                <= w_br & w_zero;
                branch_target         <= w_baddr;
            end else begin
                // Bubble: either an invalid slot or a mem op still in flight
                valid_mem_wb          <= 1'b0;
                read_data_mem_wb      <= '0;
                alu_result_mem_wb     <= '0;
                write_register_mem_wb <= '0;
                ctrl_regWrite_mem_wb  <= 1'b0;
                ctrl_memToReg_mem_wb  <= 1'b0;
                pc_src                <= 1'b0;
                branch_target         <= '0;
            end
`ifdef ALIGN_CHECK_EN
            if (w_complete && w_misalign) mem_align_err <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_h_alu   <= alu_result_ex_mem;
            r_h_wdata <= write_data_ex_mem;
            r_h_baddr <= branch_address_ex_mem;
            r_h_wreg  <= write_register_ex_mem;
            r_h_rd    <= ctrl_memRead_ex_mem;
            r_h_wr    <= ctrl_memWrite_ex_mem;
            r_h_br    <= ctrl_branch_ex_mem;
            r_h_zero  <= zero_ex_mem;
            r_h_regw  <= ctrl_regWrite_ex_mem;
            r_h_m2r   <= ctrl_memToReg_ex_mem;
        end
    end

    // Data memory has no reset; contents survive a pipeline reset
    always_ff @(posedge clk) begin
        if (w_store) r_mem[w_idx] <= w_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_stage
// Purpose  : Self-checking bench for memory_stage. One instance with
//            MEM_LATENCY=2 driven from a vector table with a scoreboard, one
//            with MEM_LATENCY=4 for the long-stall sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    typedef struct packed {
        logic        valid, rd, wr, br, zero, regw, m2r;
        logic [31:0] addr, wdata, baddr;
        logic [4:0]  wreg;
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata, alu, btgt;
        logic [4:0]  wreg;
        logic        regw, m2r, pc_src;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   sb_on = 1'b0;
    exp_t sb_q[$];
    op_t  d2, d4;
    vec_t tbl[14];

    logic        stall2, valid2, regw2, m2r2, pc2;
    logic [31:0] rdata2, alu2, btgt2;
    logic [4:0]  wreg2;
    logic        stall4, valid4, regw4, m2r4, pc4;
    logic [31:0] rdata4, alu4, btgt4;
    logic [4:0]  wreg4;
`ifdef ALIGN_CHECK_EN
    logic        aerr2, aerr4;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .valid_ex_mem(d2.valid), .alu_result_ex_mem(d2.addr), .write_data_ex_mem(d2.wdata),
        .write_register_ex_mem(d2.wreg), .zero_ex_mem(d2.zero), .branch_address_ex_mem(d2.baddr),
        .ctrl_memRead_ex_mem(d2.rd), .ctrl_memWrite_ex_mem(d2.wr), .ctrl_branch_ex_mem(d2.br),
        .ctrl_regWrite_ex_mem(d2.regw), .ctrl_memToReg_ex_mem(d2.m2r),
        .stall(stall2), .valid_mem_wb(valid2), .read_data_mem_wb(rdata2), .alu_result_mem_wb(alu2),
        .write_register_mem_wb(wreg2), .ctrl_regWrite_mem_wb(regw2), .ctrl_memToReg_mem_wb(m2r2),
        .pc_src(pc2),
`ifdef ALIGN_CHECK_EN
        .mem_align_err(aerr2),
`endif
        .branch_target(btgt2)
    );

    memory_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .valid_ex_mem(d4.valid), .alu_result_ex_mem(d4.addr), .write_data_ex_mem(d4.wdata),
        .write_register_ex_mem(d4.wreg), .zero_ex_mem(d4.zero), .branch_address_ex_mem(d4.baddr),
        .ctrl_memRead_ex_mem(d4.rd), .ctrl_memWrite_ex_mem(d4.wr), .ctrl_branch_ex_mem(d4.br),
        .ctrl_regWrite_ex_mem(d4.regw), .ctrl_memToReg_ex_mem(d4.m2r),
        .stall(stall4), .valid_mem_wb(valid4), .read_data_mem_wb(rdata4), .alu_result_mem_wb(alu4),
        .write_register_mem_wb(wreg4), .ctrl_regWrite_mem_wb(regw4), .ctrl_memToReg_mem_wb(m2r4),
        .pc_src(pc4),
`ifdef ALIGN_CHECK_EN
        .mem_align_err(aerr4),
`endif
        .branch_target(btgt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic v, rd, wr, br, z, rw, m2r,
                               input logic [31:0] a, wd, ba, input logic [4:0] wreg);
        op_t o;
        o.valid = v; o.rd = rd; o.wr = wr; o.br = br; o.zero = z; o.regw = rw; o.m2r = m2r;
        o.addr = a; o.wdata = wd; o.baddr = ba; o.wreg = wreg;
        return o;
    endfunction

    // Drive one op into the latency-2 instance, push its expected MEM/WB
    // slot, and hold it until accepted. Checks the stall length.
    task automatic issue(input op_t op, input logic [31:0] exp_rdata, input bit push);
        int   lat;
        int   st;
        exp_t e;
        lat = (op.valid && (op.rd || op.wr)) ? 2 : 1;
        @(negedge clk);
        if (push && op.valid) begin
            e.cyc = cyc + lat; e.rdata = exp_rdata; e.alu = op.addr; e.btgt = op.baddr;
            e.wreg = op.wreg; e.regw = op.regw; e.m2r = op.m2r; e.pc_src = op.br & op.zero;
            sb_q.push_back(e);
        end
        d2 = op;
        st = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (!stall2) break;
            st++;
            @(negedge clk);
        end
        chk("stall_len", st, lat - 1);
    endtask

    // Scoreboard monitor for the latency-2 instance
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_on) begin
            if (valid2) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", valid2, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("latency_cyc", cyc, e.cyc);
                    chk("read_data", rdata2, e.rdata);
                    chk("alu_result", alu2, e.alu);
                    chk("write_reg", wreg2, e.wreg);
                    chk("regWrite", regw2, e.regw);
                    chk("memToReg", m2r2, e.m2r);
                    chk("pc_src", pc2, e.pc_src);
                    chk("branch_target", btgt2, e.btgt);
                end
            end else begin
                chk("bubble_regWrite", regw2, 1'b0);
                chk("bubble_pc_src", pc2, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int st4;
        int nb4;
        //           v  rd wr br z  rw m2r addr          wdata         baddr        wreg   exp_rdata
        tbl[0]  = '{mk(1, 0, 1, 0, 0, 0, 0, 32'h10,       32'hDEADBEEF, 32'h0,       5'd0), 32'h0};
        tbl[1]  = '{mk(1, 1, 0, 0, 0, 1, 1, 32'h10,       32'h0,        32'h0,       5'd3), 32'hDEADBEEF};
        tbl[2]  = '{mk(1, 0, 0, 0, 0, 1, 0, 32'h12345678, 32'h0,        32'h0,       5'd7), 32'h0};
        tbl[3]  = '{mk(1, 0, 0, 1, 1, 0, 0, 32'h0,        32'h0,        32'h40,      5'd0), 32'h0};
        tbl[4]  = '{mk(1, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h40,      5'd0), 32'h0};
        tbl[5]  = '{mk(0, 1, 1, 0, 0, 1, 0, 32'h10,       32'h0,        32'h0,       5'd2), 32'h0};
        tbl[6]  = '{mk(1, 0, 1, 0, 0, 0, 0, 32'h400,      32'hCAFEF00D, 32'h0,       5'd0), 32'h0};
        tbl[7]  = '{mk(1, 1, 0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,       5'd4), 32'hCAFEF00D};
        tbl[8]  = '{mk(1, 0, 1, 0, 0, 0, 0, 32'h8,        32'h0A0A0A0A, 32'h0,       5'd0), 32'h0};
        tbl[9]  = '{mk(1, 1, 1, 0, 0, 1, 1, 32'h8,        32'h55555555, 32'h0,       5'd5), 32'h0A0A0A0A};
        tbl[10] = '{mk(1, 1, 0, 0, 0, 1, 1, 32'h8,        32'h0,        32'h0,       5'd6), 32'h55555555};
        tbl[11] = '{mk(1, 0, 1, 0, 0, 0, 0, 32'h20,       32'h20202020, 32'h0,       5'd0), 32'h0};
        tbl[12] = '{mk(1, 1, 0, 0, 0, 1, 1, 32'h10,       32'h0,        32'h0,       5'd8), 32'hDEADBEEF};
        tbl[13] = '{mk(1, 0, 0, 1, 1, 1, 0, 32'hAB,       32'h0,        32'h1000,    5'd9), 32'h0};

        // Reset held with a live load presented: outputs 0, no stall
        d2 = mk(1, 1, 0, 0, 0, 1, 1, 32'h10, 32'h0, 32'h0, 5'd1);
        d4 = d2;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_stall2", stall2, 1'b0);
            chk("rst_stall4", stall4, 1'b0);
            chk("rst_valid", valid2, 1'b0);
            chk("rst_rdata", rdata2, 32'h0);
            chk("rst_regw", regw2, 1'b0);
            chk("rst_pc_src", pc2, 1'b0);
            chk("rst_btgt", btgt2, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        d2 = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        d4 = d2;
        sb_on = 1'b1;

        foreach (tbl[i]) issue(tbl[i].op, tbl[i].exp_rdata, 1'b1);
        issue(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0), 32'h0, 1'b1);
        @(negedge clk);

        // Reset during WAIT of a store to 0x20 aborts the write
        sb_on = 1'b0;
        d2 = mk(1, 0, 1, 0, 0, 0, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 5'd0);
        #1 chk("abort_stall_idle", stall2, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("abort_stall_rst", stall2, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        d2 = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        #1 chk("abort_valid", valid2, 1'b0);
        sb_on = 1'b1;
        issue(mk(1, 1, 0, 0, 0, 1, 1, 32'h20, 32'h0, 32'h0, 5'd10), 32'h20202020, 1'b1);
        issue(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0), 32'h0, 1'b1);
        @(negedge clk);

`ifdef ALIGN_CHECK_EN
        sb_on = 1'b0;
        chk("align_err_clear", aerr2, 1'b0);
        issue(mk(1, 0, 1, 0, 0, 0, 0, 32'h22, 32'hBADBAD00, 32'h0, 5'd0), 32'h0, 1'b0);
        issue(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0), 32'h0, 1'b0);
        @(negedge clk);
        chk("align_err_set", aerr2, 1'b1);
        sb_on = 1'b1;
        issue(mk(1, 1, 0, 0, 0, 1, 1, 32'h20, 32'h0, 32'h0, 5'd11), 32'h20202020, 1'b1);
        issue(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0), 32'h0, 1'b1);
        @(negedge clk);
        chk("align_err_sticky", aerr2, 1'b1);
`endif
        chk("sb_drain", sb_q.size(), 0);

        // Latency-4 instance: store, then load with garbage driven during stall
        @(negedge clk);
        d4 = mk(1, 0, 1, 0, 0, 0, 0, 32'h30, 32'h600DF00D, 32'h0, 5'd0);
        st4 = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (!stall4) break;
            st4++;
            @(negedge clk);
        end
        chk("l4_store_stall", st4, 3);
        @(negedge clk);
        d4 = mk(1, 1, 0, 0, 0, 1, 1, 32'h30, 32'h0, 32'h0, 5'd9);
        st4 = 0;
        nb4 = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (stall4) st4++;
            @(posedge clk); #1;
            if (!valid4) nb4++;
            @(negedge clk);
            d4 = mk(1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h00000BAD, 32'h0, 5'd31);
        end
        #1 chk("l4_stall_end", stall4, 1'b0);
        @(posedge clk); #1;
        chk("l4_valid", valid4, 1'b1);
        chk("l4_rdata", rdata4, 32'h600DF00D);
        chk("l4_alu", alu4, 32'h30);
        chk("l4_wreg", wreg4, 5'd9);
        chk("l4_regw", regw4, 1'b1);
        chk("l4_load_stall", st4, 3);
        chk("l4_bubbles", nb4, 3);
        @(negedge clk);
        d4 = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
        chk("l4_after_valid", valid4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Consumes the registered ALU result, store data, destination register, zero flag and branch target from EX, plus the MEM/WB control bits.
- Performs word loads and stores to an internal data memory with configurable multi-cycle latency, and stalls upstream while an access is in flight.
- Drives the MEM/WB pipeline register and the registered branch decision (pc_src) back to fetch.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit data memory words; power of two.
- MEM_LATENCY, 2, clock edges from op presentation to MEM/WB update for memory ops; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_ex_mem  in  1  EX output slot holds a real instruction
- alu_result_ex_mem  in  32  byte address for memory ops; result for ALU ops
- write_data_ex_mem  in  32  store data
- write_register_ex_mem  in  5  destination register
- zero_ex_mem  in  1  branch-equal flag
- branch_address_ex_mem  in  32  branch target
- ctrl_memRead_ex_mem  in  1  load
- ctrl_memWrite_ex_mem  in  1  store
- ctrl_branch_ex_mem  in  1  beq
- ctrl_regWrite_ex_mem  in  1  passed to WB
- ctrl_memToReg_ex_mem  in  1  passed to WB
- stall  out  1  upstream must hold all _ex_mem inputs stable
- valid_mem_wb  out  1  MEM/WB slot valid
- read_data_mem_wb  out  32  load data
- alu_result_mem_wb  out  32  registered ALU result
- write_register_mem_wb  out  5  registered destination register
- ctrl_regWrite_mem_wb  out  1  registered; forced to 0 when the slot is not valid
- ctrl_memToReg_mem_wb  out  1  registered
- pc_src  out  1  taken-branch pulse
- branch_target  out  32  registered branch_address_ex_mem

Behaviour:
- **Reset.** On a reset edge, all registered outputs go to 0 and the FSM goes to IDLE. stall is 0 while reset is high. Memory contents are not cleared. Reset during WAIT aborts the op: no write occurs and no MEM/WB update occurs.
- **Op classes.**
  - mem_op = valid & (memRead | memWrite).
  - Non-mem valid op: 1-cycle pass-through; MEM/WB is updated at the next edge.
  - Invalid input: a bubble is written, i.e. valid_mem_wb = 0 and ctrl_regWrite_mem_wb = 0.
- **Word index.** word index = alu_result[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS×4.
- **FSM states:** IDLE, WAIT.
- **IDLE:**
  - Non-mem op, or mem_op with MEM_LATENCY = 1: stall = 0. The access or pass-through completes at this edge.
  - mem_op with MEM_LATENCY > 1: stall = 1 (combinational). At the edge:
    - latch all inputs into hold registers;
    - cnt ← MEM_LATENCY−2;
    - go to WAIT;
    - write a bubble to MEM/WB.
- **WAIT:**
  - stall = (cnt ≠ 0). Live inputs are ignored; the hold registers are used.
  - cnt ≠ 0: cnt decrements and a bubble is written.
  - cnt = 0: perform the access, update MEM/WB with valid = 1, go to IDLE.
- **Stall timing.** stall is high for exactly MEM_LATENCY−1 consecutive cycles per mem op. Back-to-back mem ops are fully serialized.
- **Access at the completing edge:**
  - Store: mem[idx] ← write_data.
  - Load: read_data_mem_wb ← mem[idx].
  - Both read and write set: the write occurs, and read_data_mem_wb receives the pre-write value.
  - Non-load: read_data_mem_wb ← 0.
- **Branch.**
  - pc_src ← valid & ctrl_branch & zero, registered in the same edge as the MEM/WB update; it is a 1-cycle pulse.
  - branch_target is registered alongside pc_src.
  - Branches are non-mem ops and are never stalled.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined:
  - Adds output mem_align_err (1 bit, reset 0).
  - A mem op with alu_result[1:0] ≠ 0 sets mem_align_err sticky until reset, suppresses the store, returns read_data_mem_wb = 0, and forces ctrl_regWrite_mem_wb = 0.
  - Timing and stall are unchanged.
- Undefined: the port is absent and alu_result[1:0] is ignored.

Test Plan:
1. Reset held 3 cycles with memRead = 1 and valid = 1 → all outputs 0, stall = 0, valid_mem_wb = 0.
2. Store 0xDEADBEEF to 0x10, then load from 0x10 (MEM_LATENCY = 2) → stall high 1 cycle per op; the load's valid_mem_wb = 1 with read_data_mem_wb = 0xDEADBEEF exactly 2 edges after presentation.
3. Branch with ctrl_branch = 1, zero = 1, target 0x40 → pc_src = 1 for exactly one cycle, branch_target = 0x40, stall = 0; the same op with zero = 0 gives pc_src = 0.
4. MEM_LATENCY = 4: load issued and upstream inputs changed to garbage during stall → stall high 3 cycles, result uses the original address, 3 bubbles then a valid slot.
5. Store to 0x400 with DEPTH_WORDS = 256, then load from 0x0 → returns the stored value (wrap-around).
6. Reset asserted during WAIT of a store to 0x20 → after release, a load from 0x20 returns the prior contents; with ALIGN_CHECK_EN, a store to 0x22 sets mem_align_err = 1 and leaves mem[8] unchanged.
